// File: rtl/param_pass_auth.sv
// Purpose: authenticates a user by comparing entered digits with a per-user password in a latency-ROM; offers guest bypass and brute-force lockout.
// Latency: login rises N_DIGITS*(ROM_LAT+1)+1 clocks after the last digit is accepted; the ROM is read one digit at a time.
// Backpressure: none; digits arriving outside ENTRY are dropped, and busy flags the fetch/compare window.
// Ports: clk/rst (sync, active-low); id_valid/user_id/guest start a session; digit_valid/digit carry the entered digits;
//        logout_req ends or aborts a session; rom_addr/rom_data form the password ROM port;
//        login/logout/guest_mode/locked/fail/tries_left/busy are registered status outputs.
module param_pass_auth #(
    parameter int N_DIGITS    = 4,
    parameter int DIGIT_W     = 4,
    parameter int ID_W        = 5,
    parameter int ADDR_W      = 7,
    parameter int ROM_LAT     = 2,
    parameter int MAX_TRIES   = 4,
    parameter int LOCK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [ID_W-1:0]    user_id,
    input  logic               guest,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               logout_req,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DIGIT_W-1:0] rom_data,
    output logic               login,
    output logic               logout,
    output logic               guest_mode,
    output logic               locked,
    output logic               fail,
    output logic [3:0]         tries_left,
    output logic               busy
);

    localparam int BUF_W = N_DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(N_DIGITS + 1);
    localparam int LAT_W = 3;
    localparam int LCK_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N_DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_WAIT    = 3'd2,
        S_CATCH   = 3'd3,
        S_COMPARE = 3'd4,
        S_PASSED  = 3'd5,
        S_LOCKOUT = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [BUF_W-1:0]   user_buf_q, user_buf_d;
    logic [BUF_W-1:0]   rom_buf_q, rom_buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LAT_W-1:0]   wait_q, wait_d;
    logic [LCK_W-1:0]   lock_q, lock_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               login_q, login_d;
    logic               logout_q, logout_d;
    logic               guest_q, guest_d;
    logic               locked_q, locked_d;
    logic               fail_q, fail_d;
    logic [3:0]         tries_q, tries_d;
    logic               busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        user_buf_d = user_buf_q;
        rom_buf_d  = rom_buf_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        lock_d     = lock_q;
        rom_addr_d = rom_addr_q;
        login_d    = login_q;
        logout_d   = logout_q;
        guest_d    = guest_q;
        locked_d   = locked_q;
        fail_d     = 1'b0;
        tries_d    = tries_q;

        case (state_q)
            S_IDLE: begin
                // Guest wins over a simultaneous id match.
                if (guest) begin
                    state_d  = S_PASSED;
                    login_d  = 1'b1;
                    logout_d = 1'b0;
                    guest_d  = 1'b1;
                end else if (id_valid) begin
                    base_d     = ADDR_W'(user_id) * ADDR_W'(N_DIGITS);
                    user_buf_d = '0;
                    rom_buf_d  = '0;
                    cnt_d      = '0;
                    logout_d   = 1'b0;
                    state_d    = S_ENTRY;
                end
            end

            S_ENTRY: begin
                if (logout_req) begin
                    state_d  = S_IDLE;
                    login_d  = 1'b0;
                    logout_d = 1'b1;
                    guest_d  = 1'b0;
                end else if (digit_valid) begin
                    // First digit ends up in the most significant slot.
                    user_buf_d = (user_buf_q << DIGIT_W) | BUF_W'(digit);
                    if (cnt_q == LAST_DIGIT) begin
                        cnt_d      = '0;
                        rom_addr_d = base_q;
                        wait_d     = LAT_W'(ROM_LAT - 1);
                        state_d    = S_WAIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_WAIT: begin
                if (logout_req) begin
                    state_d  = S_IDLE;
                    login_d  = 1'b0;
                    logout_d = 1'b1;
                    guest_d  = 1'b0;
                end else if (wait_q == '0) begin
                    state_d = S_CATCH;
                end else begin
                    wait_d = wait_q - LAT_W'(1);
                end
            end

            S_CATCH: begin
                if (logout_req) begin
                    state_d  = S_IDLE;
                    login_d  = 1'b0;
                    logout_d = 1'b1;
                    guest_d  = 1'b0;
                end else begin
                    rom_buf_d = (rom_buf_q << DIGIT_W) | BUF_W'(rom_data);
                    if (cnt_q == LAST_DIGIT) begin
                        cnt_d   = '0;
                        state_d = S_COMPARE;
                    end else begin
                        cnt_d      = cnt_q + CNT_W'(1);
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        wait_d     = LAT_W'(ROM_LAT - 1);
                        state_d    = S_WAIT;
                    end
                end
            end

            S_COMPARE: begin
                // A logout request overrides the compare verdict.
                if (logout_req) begin
                    state_d  = S_IDLE;
                    login_d  = 1'b0;
                    logout_d = 1'b1;
                    guest_d  = 1'b0;
                end else if (user_buf_q == rom_buf_q) begin
                    state_d  = S_PASSED;
                    login_d  = 1'b1;
                    logout_d = 1'b0;
                    guest_d  = 1'b0;
                end else begin
                    fail_d  = 1'b1;
                    tries_d = tries_q - 4'd1;
                    if (tries_q == 4'd1) begin
                        state_d  = S_LOCKOUT;
                        locked_d = 1'b1;
                        lock_d   = LCK_W'(LOCK_CYCLES - 1);
                    end else begin
                        user_buf_d = '0;
                        rom_buf_d  = '0;
                        cnt_d      = '0;
                        state_d    = S_ENTRY;
                    end
                end
            end

            S_PASSED: begin
                if (logout_req) begin
                    state_d  = S_IDLE;
                    login_d  = 1'b0;
                    logout_d = 1'b1;
                    guest_d  = 1'b0;
                    tries_d  = 4'(MAX_TRIES);
                end
            end

            S_LOCKOUT: begin
                if (lock_q == '0) begin
                    state_d  = S_IDLE;
                    locked_d = 1'b0;
                    logout_d = 1'b1;
                    tries_d  = 4'(MAX_TRIES);
                end else begin
                    lock_d = lock_q - LCK_W'(1);
                end
            end

            default: begin
                // Stray encoding: land in IDLE with the power-on outputs.
                state_d    = S_IDLE;
                base_d     = '0;
                user_buf_d = '0;
                rom_buf_d  = '0;
                cnt_d      = '0;
                wait_d     = '0;
                lock_d     = '0;
                rom_addr_d = '0;
                login_d    = 1'b0;
                logout_d   = 1'b1;
                guest_d    = 1'b0;
                locked_d   = 1'b0;
                tries_d    = 4'(MAX_TRIES);
            end
        endcase

        busy_d = (state_d == S_WAIT) || (state_d == S_CATCH) || (state_d == S_COMPARE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            user_buf_q <= '0;
            rom_buf_q  <= '0;
            cnt_q      <= '0;
            wait_q     <= '0;
            lock_q     <= '0;
            rom_addr_q <= '0;
            login_q    <= 1'b0;
            logout_q   <= 1'b1;
            guest_q    <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
            tries_q    <= 4'(MAX_TRIES);
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            user_buf_q <= user_buf_d;
            rom_buf_q  <= rom_buf_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            lock_q     <= lock_d;
            rom_addr_q <= rom_addr_d;
            login_q    <= login_d;
            logout_q   <= logout_d;
            guest_q    <= guest_d;
            locked_q   <= locked_d;
            fail_q     <= fail_d;
            tries_q    <= tries_d;
            busy_q     <= busy_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign login      = login_q;
    assign logout     = logout_q;
    assign guest_mode = guest_q;
    assign locked     = locked_q;
    assign fail       = fail_q;
    assign tries_left = tries_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_param_pass_auth.sv
// Bench for param_pass_auth: a pipelined ROM model, a session-level reference model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_param_pass_auth;

    localparam int N_DIGITS    = 4;
    localparam int DIGIT_W     = 4;
    localparam int ID_W        = 5;
    localparam int ADDR_W      = 7;
    localparam int ROM_LAT     = 2;
    localparam int MAX_TRIES   = 4;
    localparam int LOCK_CYCLES = 16;
    localparam int ROM_SIZE    = 1 << ADDR_W;
    localparam int FETCH_CYC   = N_DIGITS * (ROM_LAT + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, id_valid, guest, digit_valid, logout_req;
    logic [ID_W-1:0]    user_id;
    logic [DIGIT_W-1:0] digit, rom_data;
    logic [ADDR_W-1:0]  rom_addr;
    logic               login, logout, guest_mode, locked, fail, busy;
    logic [3:0]         tries_left;

    param_pass_auth #(
        .N_DIGITS(N_DIGITS), .DIGIT_W(DIGIT_W), .ID_W(ID_W), .ADDR_W(ADDR_W),
        .ROM_LAT(ROM_LAT), .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .user_id(user_id), .guest(guest),
        .digit_valid(digit_valid), .digit(digit), .logout_req(logout_req),
        .rom_addr(rom_addr), .rom_data(rom_data), .login(login), .logout(logout),
        .guest_mode(guest_mode), .locked(locked), .fail(fail), .tries_left(tries_left),
        .busy(busy)
    );

    // Password ROM with ROM_LAT registered stages.
    logic [DIGIT_W-1:0] mem [ROM_SIZE];
    logic [DIGIT_W-1:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= mem[rom_addr];
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // ---------------- session-level reference model ----------------
    localparam int M_IDLE = 0, M_ENTER = 1, M_FETCH = 2, M_PASS = 3, M_LOCK = 4;
    int m_mode, m_base, m_t, m_lk, m_addr, m_tries;
    bit m_login, m_logout, m_guest, m_locked, m_fail, m_busy;
    int m_digits[$];

    function automatic bit pw_ok();
        for (int i = 0; i < N_DIGITS; i++)
            if (m_digits[i] != int'(mem[(m_base + i) % ROM_SIZE])) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_abort();
        m_mode = M_IDLE; m_login = 0; m_logout = 1; m_guest = 0; m_busy = 0;
    endtask

    always @(posedge clk) begin
        int slot;
        m_fail = 0;
        if (!rst) begin
            m_mode = M_IDLE; m_login = 0; m_logout = 1; m_guest = 0; m_locked = 0;
            m_busy = 0; m_tries = MAX_TRIES; m_addr = 0; m_digits.delete();
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (guest) begin
                        m_mode = M_PASS; m_login = 1; m_logout = 0; m_guest = 1;
                    end else if (id_valid) begin
                        m_base = (int'(user_id) * N_DIGITS) % ROM_SIZE;
                        m_digits.delete(); m_logout = 0; m_mode = M_ENTER;
                    end
                end
                M_ENTER: begin
                    if (logout_req) m_abort();
                    else if (digit_valid) begin
                        m_digits.push_back(int'(digit));
                        if (m_digits.size() == N_DIGITS) begin
                            m_mode = M_FETCH; m_t = 0; m_addr = m_base; m_busy = 1;
                        end
                    end
                end
                M_FETCH: begin
                    if (logout_req) m_abort();
                    else begin
                        m_t++;
                        if (m_t <= FETCH_CYC) begin
                            slot = m_t / (ROM_LAT + 1);
                            if (slot > N_DIGITS - 1) slot = N_DIGITS - 1;
                            m_addr = (m_base + slot) % ROM_SIZE;
                        end else begin
                            m_busy = 0;
                            if (pw_ok()) begin
                                m_mode = M_PASS; m_login = 1; m_logout = 0; m_guest = 0;
                            end else begin
                                m_fail = 1; m_tries--;
                                if (m_tries == 0) begin
                                    m_mode = M_LOCK; m_locked = 1; m_lk = 0;
                                end else begin
                                    m_mode = M_ENTER; m_digits.delete();
                                end
                            end
                        end
                    end
                end
                M_PASS: begin
                    if (logout_req) begin
                        m_abort(); m_tries = MAX_TRIES;
                    end
                end
                default: begin
                    m_lk++;
                    if (m_lk == LOCK_CYCLES) begin
                        m_mode = M_IDLE; m_locked = 0; m_logout = 1; m_tries = MAX_TRIES;
                    end
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if ({login, logout, guest_mode, locked, fail, tries_left, busy, rom_addr} !==
                {m_login, m_logout, m_guest, m_locked, m_fail, 4'(m_tries), m_busy, ADDR_W'(m_addr)}) begin
                n_errors++;
                $display("FAIL cycle_compare @%0t got login=%b logout=%b guest=%b locked=%b fail=%b tries=%0d busy=%b addr=%0d, expected login=%b logout=%b guest=%b locked=%b fail=%b tries=%0d busy=%b addr=%0d",
                         $time, login, logout, guest_mode, locked, fail, tries_left, busy, rom_addr,
                         m_login, m_logout, m_guest, m_locked, m_fail, m_tries, m_busy, m_addr);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic start_user(input int id);
        id_valid = 1; user_id = ID_W'(id);
        step();
        id_valid = 0;
    endtask

    task automatic enter(input int a, input int b, input int c, input int d);
        int v[4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            digit_valid = 1; digit = DIGIT_W'(v[i]);
            step();
        end
        digit_valid = 0;
    endtask

    task automatic do_logout();
        logout_req = 1;
        step();
        logout_req = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 0; id_valid = 0; user_id = '0; guest = 0; digit_valid = 0; digit = '0; logout_req = 0;
        for (int i = 0; i < ROM_SIZE; i++) mem[i] = DIGIT_W'($urandom);
        mem[12] = 4'd1; mem[13] = 4'd2; mem[14] = 4'd3; mem[15] = 4'd4;

        step(); step();
        chk_en = 1'b1;
        chk("reset_login", int'(login), 0);
        chk("reset_logout", int'(logout), 1);
        chk("reset_locked", int'(locked), 0);
        chk("reset_tries", int'(tries_left), 4);
        chk("reset_addr", int'(rom_addr), 0);
        chk("reset_busy", int'(busy), 0);
        rst = 1;
        step();

        // Correct password for user 3: ROM walk and login timing.
        start_user(3);
        enter(1, 2, 3, 4);
        chk("fetch_addr_first", int'(rom_addr), 12);
        chk("fetch_busy", int'(busy), 1);
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 2)  chk("fetch_addr_hold", int'(rom_addr), 12);
            if (k == 3)  chk("fetch_addr_13", int'(rom_addr), 13);
            if (k == 6)  chk("fetch_addr_14", int'(rom_addr), 14);
            if (k == 9)  chk("fetch_addr_15", int'(rom_addr), 15);
            if (k == 12) chk("login_not_early", int'(login), 0);
            if (k == 13) begin
                chk("login_at_13", int'(login), 1);
                chk("logout_low_on_login", int'(logout), 0);
                chk("user_not_guest", int'(guest_mode), 0);
            end
        end
        do_logout();
        chk("logout_after_pass", int'(logout), 1);
        chk("tries_after_pass", int'(tries_left), 4);

        // One wrong password, then the right one.
        start_user(3);
        enter(1, 2, 3, 5);
        repeat (12) step();
        chk("fail_not_early", int'(fail), 0);
        step();
        chk("fail_pulse", int'(fail), 1);
        chk("tries_after_fail", int'(tries_left), 3);
        step();
        chk("fail_one_cycle", int'(fail), 0);
        enter(1, 2, 3, 4);
        repeat (13) step();
        chk("login_after_retry", int'(login), 1);
        do_logout();

        // Abort during WAIT after one failure keeps the spent attempt.
        start_user(3);
        enter(1, 2, 3, 5);
        repeat (13) step();
        enter(1, 2, 3, 4);
        step();
        do_logout();
        chk("abort_logout", int'(logout), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_tries_kept", int'(tries_left), 3);

        // Guest beats id_valid; no ROM access.
        guest = 1; id_valid = 1; user_id = ID_W'(3);
        step();
        guest = 0; id_valid = 0;
        chk("guest_mode", int'(guest_mode), 1);
        chk("guest_busy", int'(busy), 0);
        step();
        chk("guest_no_rom", int'(rom_addr), 12);
        do_logout();
        chk("guest_logout", int'(logout), 1);
        chk("guest_cleared", int'(guest_mode), 0);
        chk("guest_tries_reload", int'(tries_left), 4);

        // Four wrong passwords: lockout that ignores inputs.
        start_user(3);
        for (int a = 0; a < 4; a++) begin
            enter(9, 9, 9, 9);
            repeat (13) step();
        end
        chk("lock_entered", int'(locked), 1);
        chk("lock_tries_zero", int'(tries_left), 0);
        for (int k = 1; k <= 15; k++) begin
            id_valid = 1; digit_valid = 1; digit = DIGIT_W'($urandom); guest = 1'($urandom);
            step();
            chk("lock_held", int'(locked), 1);
        end
        id_valid = 0; digit_valid = 0; guest = 0;
        step();
        chk("lock_exit", int'(locked), 0);
        chk("lock_exit_logout", int'(logout), 1);
        chk("lock_exit_tries", int'(tries_left), 4);

        // Reset during WAIT.
        start_user(3);
        enter(1, 2, 3, 4);
        step();
        rst = 0;
        step();
        rst = 1;
        chk("rst_wait_login", int'(login), 0);
        chk("rst_wait_logout", int'(logout), 1);
        chk("rst_wait_addr", int'(rom_addr), 0);
        chk("rst_wait_busy", int'(busy), 0);

        // Reset during LOCKOUT.
        start_user(3);
        for (int a = 0; a < 4; a++) begin
            enter(9, 9, 9, 9);
            repeat (13) step();
        end
        repeat (5) step();
        chk("rst_lock_pre", int'(locked), 1);
        rst = 0;
        step();
        rst = 1;
        chk("rst_lock_locked", int'(locked), 0);
        chk("rst_lock_logout", int'(logout), 1);
        chk("rst_lock_tries", int'(tries_left), 4);
        chk("rst_lock_addr", int'(rom_addr), 0);

        // Random traffic; digits mostly follow the selected user's password.
        for (int c = 0; c < 20000; c++) begin
            rst      = ($urandom_range(0, 499) != 0);
            guest    = ($urandom_range(0, 19) == 0);
            id_valid = ($urandom_range(0, 3) == 0);
            user_id  = ID_W'($urandom);
            logout_req = (m_mode == M_PASS) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) == 0);
            digit_valid = 1'($urandom);
            if (m_mode == M_ENTER && $urandom_range(0, 9) != 0)
                digit = mem[(m_base + m_digits.size()) % ROM_SIZE];
            else
                digit = DIGIT_W'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
